// File: rtl/iccm_arb_pkg.sv
// Shared types and default widths for the ICCM port arbiter.
package iccm_arb_pkg;

  localparam int unsigned DefaultAw = 12;
  localparam int unsigned DefaultDw = 32;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_BUS,
    GNT_PROG
  } grant_e;

  typedef struct packed {
    logic [DefaultAw-1:0] addr;
    logic [DefaultDw-1:0] data;
  } prog_wr_t;

endpackage

// File: rtl/iccm_wr_fifo.sv
// Synchronous FIFO buffering programmer writes; pointers carry one extra wrap bit.
module iccm_wr_fifo
  import iccm_arb_pkg::*;
#(
  parameter int unsigned Depth   = 4,
  parameter type         entry_t = prog_wr_t
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  entry_t wdata_i,
  input  logic   pop_i,
  output entry_t rdata_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW:0] wr_q, wr_d;
  logic [PtrW:0] rd_q, rd_d;
  entry_t        mem_q [Depth];
  logic          push_ok, pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PtrW] != rd_q[PtrW]) && (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);
  assign rdata_o = mem_q[rd_q[PtrW-1:0]];

  // A pop only retires an existing head; a full FIFO takes a push only alongside a pop.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Next pointer values.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
  end

  // Pointer registers; reset discards all buffered entries.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Entry storage, no reset needed since validity comes from the pointers.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[PtrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/iccm_port_arbiter.sv
// Shares the single-port ICCM between the bus adapter and the buffered boot programmer.
module iccm_port_arbiter
  import iccm_arb_pkg::*;
#(
  parameter int unsigned AW        = DefaultAw,
  parameter int unsigned DW        = DefaultDw,
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned MaxWait   = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          bus_req_i,
  input  logic          bus_we_i,
  input  logic [AW-1:0] bus_addr_i,
  input  logic [DW-1:0] bus_wdata_i,
  input  logic [DW-1:0] bus_wmask_i,
  output logic          bus_gnt_o,
  output logic          bus_rvalid_o,
  output logic [DW-1:0] bus_rdata_o,
  input  logic          prog_we_i,
  input  logic [AW-1:0] prog_addr_i,
  input  logic [DW-1:0] prog_wdata_i,
  input  logic          prog_lock_i,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [DW-1:0] mem_wmask_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          fifo_empty_o,
  output logic          ovf_o
);

  localparam int unsigned CntW = $clog2(MaxWait + 1);

  // Same layout as prog_wr_t but follows this instance's AW/DW.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  grant_e        gnt;
  entry_t        push_entry, head;
  logic          fifo_full, fifo_empty, pop;
  logic [CntW-1:0] starve_q, starve_d;
  logic          rd_q, rd_d;
  logic          ovf_q, ovf_d;

  assign push_entry = '{addr: prog_addr_i, data: prog_wdata_i};
  assign pop        = (gnt == GNT_PROG);

  iccm_wr_fifo #(
    .Depth   (FifoDepth),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (prog_we_i),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Grant decision and memory port mux; the winner drives mem_* in the same cycle.
  always_comb begin
    gnt         = GNT_NONE;
    bus_gnt_o   = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    if (!fifo_empty && (prog_lock_i || starve_q == CntW'(MaxWait))) gnt = GNT_PROG;
    else if (bus_req_i)                                             gnt = GNT_BUS;
    else if (!fifo_empty)                                           gnt = GNT_PROG;
    unique case (gnt)
      GNT_BUS: begin
        bus_gnt_o   = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = bus_we_i;
        mem_addr_o  = bus_addr_i;
        mem_wdata_o = bus_wdata_i;
        mem_wmask_o = bus_wmask_i;
      end
      GNT_PROG: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = head.addr;
        mem_wdata_o = head.data;
        mem_wmask_o = '1;
      end
      default: ;
    endcase
  end

  // Starvation counter, read tracker and sticky overflow next-state.
  always_comb begin
    starve_d = starve_q;
    if (gnt == GNT_PROG || fifo_empty) begin
      starve_d = '0;
    end else if (gnt == GNT_BUS && starve_q != CntW'(MaxWait)) begin
      starve_d = starve_q + CntW'(1);
    end
    rd_d  = (gnt == GNT_BUS) && !bus_we_i;
    ovf_d = ovf_q || (prog_we_i && fifo_full && !pop);
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= '0;
      rd_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      starve_q <= starve_d;
      rd_q     <= rd_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus_rvalid_o = rd_q;
  assign bus_rdata_o  = mem_rdata_i;
  assign fifo_empty_o = fifo_empty;
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_iccm_port_arbiter.sv
// Directed self-checking bench for iccm_port_arbiter.
module tb_iccm_port_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          bus_req_i, bus_we_i;
  logic [AW-1:0] bus_addr_i;
  logic [DW-1:0] bus_wdata_i, bus_wmask_i;
  logic          bus_gnt_o, bus_rvalid_o;
  logic [DW-1:0] bus_rdata_o;
  logic          prog_we_i;
  logic [AW-1:0] prog_addr_i;
  logic [DW-1:0] prog_wdata_i;
  logic          prog_lock_i;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_wmask_o;
  logic [DW-1:0] mem_rdata_i;
  logic          fifo_empty_o, ovf_o;

  int checks   = 0;
  int failures = 0;

  iccm_port_arbiter #(
    .AW        (AW),
    .DW        (DW),
    .FifoDepth (4),
    .MaxWait   (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .bus_req_i    (bus_req_i),
    .bus_we_i     (bus_we_i),
    .bus_addr_i   (bus_addr_i),
    .bus_wdata_i  (bus_wdata_i),
    .bus_wmask_i  (bus_wmask_i),
    .bus_gnt_o    (bus_gnt_o),
    .bus_rvalid_o (bus_rvalid_o),
    .bus_rdata_o  (bus_rdata_o),
    .prog_we_i    (prog_we_i),
    .prog_addr_i  (prog_addr_i),
    .prog_wdata_i (prog_wdata_i),
    .prog_lock_i  (prog_lock_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_wmask_o  (mem_wmask_o),
    .mem_rdata_i  (mem_rdata_i),
    .fifo_empty_o (fifo_empty_o),
    .ovf_o        (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge; inputs change here, checks follow #1 later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; bus_req_i = 1'b0; bus_we_i = 1'b0; bus_addr_i = '0;
    bus_wdata_i = '0; bus_wmask_i = '0; prog_we_i = 1'b0; prog_addr_i = '0;
    prog_wdata_i = '0; prog_lock_i = 1'b0; mem_rdata_i = '0;
    step(); step();
    rst_i = 1'b0;
    #1;
    checks++;
    if (fifo_empty_o !== 1'b1) begin
      failures++; $display("FAIL reset_fifo_empty got=%b exp=1", fifo_empty_o);
    end
    checks++;
    if ({ovf_o, bus_rvalid_o, bus_gnt_o, mem_req_o} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0000", {ovf_o, bus_rvalid_o, bus_gnt_o, mem_req_o});
    end
  endtask

  task automatic test_prog_write();
    step();
    prog_we_i = 1'b1; prog_addr_i = 12'h004; prog_wdata_i = 32'hDEADBEEF;
    #1;
    checks++;
    if (mem_we_o !== 1'b0) begin
      failures++; $display("FAIL prog_latency got mem_we=%b exp=0", mem_we_o);
    end
    step();
    prog_we_i = 1'b0;
    #1;
    checks++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o, bus_gnt_o} !==
        {1'b1, 1'b1, 12'h004, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b0}) begin
      failures++;
      $display("FAIL prog_write got req=%b we=%b addr=%h data=%h mask=%h exp 1 1 004 deadbeef ffffffff",
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o);
    end
    step();
    #1;
    checks++;
    if ({fifo_empty_o, mem_req_o} !== 2'b10) begin
      failures++; $display("FAIL prog_drained got empty=%b req=%b exp 1 0", fifo_empty_o, mem_req_o);
    end
  endtask

  task automatic test_bus_read();
    step();
    bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = 12'h010;
    #1;
    checks++;
    if ({bus_gnt_o, mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b1, 1'b0, 12'h010}) begin
      failures++;
      $display("FAIL bus_read_gnt got gnt=%b req=%b we=%b addr=%h exp 1 1 0 010",
               bus_gnt_o, mem_req_o, mem_we_o, mem_addr_o);
    end
    step();
    bus_req_i = 1'b0; mem_rdata_i = 32'hCAFEF00D;
    #1;
    checks++;
    if ({bus_rvalid_o, bus_rdata_o} !== {1'b1, 32'hCAFEF00D}) begin
      failures++;
      $display("FAIL bus_rvalid got v=%b d=%h exp 1 cafef00d", bus_rvalid_o, bus_rdata_o);
    end
    step();
    bus_req_i = 1'b1; bus_we_i = 1'b1; bus_addr_i = 12'h020;
    bus_wdata_i = 32'h00001234; bus_wmask_i = 32'h000000FF;
    #1;
    checks++;
    if ({bus_gnt_o, mem_we_o, mem_wdata_o, mem_wmask_o} !==
        {1'b1, 1'b1, 32'h00001234, 32'h000000FF}) begin
      failures++;
      $display("FAIL bus_write got gnt=%b we=%b data=%h mask=%h exp 1 1 00001234 000000ff",
               bus_gnt_o, mem_we_o, mem_wdata_o, mem_wmask_o);
    end
    step();
    bus_req_i = 1'b0; bus_we_i = 1'b0;
    #1;
    checks++;
    if (bus_rvalid_o !== 1'b0) begin
      failures++; $display("FAIL bus_write_no_rvalid got=%b exp=0", bus_rvalid_o);
    end
  endtask

  task automatic test_starvation();
    step();
    bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = 12'h030;
    prog_we_i = 1'b1; prog_addr_i = 12'h008; prog_wdata_i = 32'h00000011;
    step();
    prog_we_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus_gnt_o !== 1'b1) begin
        failures++; $display("FAIL starve_bus_%0d got gnt=%b exp=1", i, bus_gnt_o);
      end
      step();
    end
    #1;
    checks++;
    if ({bus_gnt_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b0, 1'b1, 12'h008, 32'h11}) begin
      failures++;
      $display("FAIL starve_forced got gnt=%b we=%b addr=%h data=%h exp 0 1 008 00000011",
               bus_gnt_o, mem_we_o, mem_addr_o, mem_wdata_o);
    end
    step();
    #1;
    checks++;
    if ({bus_gnt_o, fifo_empty_o} !== 2'b11) begin
      failures++; $display("FAIL starve_resume got gnt=%b empty=%b exp 1 1", bus_gnt_o, fifo_empty_o);
    end
    bus_req_i = 1'b0;
  endtask

  task automatic test_lock();
    logic [AW-1:0] addr;
    // Queue three writes while the bus holds the port.
    bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = 12'h040;
    for (int i = 0; i < 3; i++) begin
      step();
      prog_we_i = 1'b1; prog_addr_i = AW'(12'h100 + i); prog_wdata_i = 32'hA0 + i;
    end
    step();
    prog_we_i = 1'b0; prog_lock_i = 1'b1;
    #1;
    checks++;
    if (bus_rvalid_o !== 1'b1) begin
      failures++; $display("FAIL lock_rvalid_kept got=%b exp=1", bus_rvalid_o);
    end
    for (int i = 0; i < 3; i++) begin
      addr = AW'(12'h100 + i);
      checks++;
      if ({bus_gnt_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b0, 1'b1, addr, 32'hA0 + i}) begin
        failures++;
        $display("FAIL lock_prog_%0d got gnt=%b we=%b addr=%h data=%h exp 0 1 %h %h",
                 i, bus_gnt_o, mem_we_o, mem_addr_o, mem_wdata_o, addr, 32'hA0 + i);
      end
      step();
      #1;
    end
    checks++;
    if ({bus_gnt_o, fifo_empty_o} !== 2'b11) begin
      failures++; $display("FAIL lock_bus_after got gnt=%b empty=%b exp 1 1", bus_gnt_o, fifo_empty_o);
    end
    step();
    prog_lock_i = 1'b0; bus_req_i = 1'b0;
  endtask

  task automatic test_overflow();
    logic [AW-1:0] addr;
    bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = 12'h050;
    for (int i = 0; i < 5; i++) begin
      step();
      prog_we_i = 1'b1; prog_addr_i = AW'(12'h200 + i); prog_wdata_i = 32'hB0 + i;
      if (i == 4) begin
        #1;
        checks++;
        if ({ovf_o, bus_gnt_o} !== 2'b01) begin
          failures++; $display("FAIL ovf_before got ovf=%b gnt=%b exp 0 1", ovf_o, bus_gnt_o);
        end
      end
    end
    step();
    prog_we_i = 1'b0; bus_req_i = 1'b0;
    #1;
    checks++;
    if (ovf_o !== 1'b1) begin
      failures++; $display("FAIL ovf_set got=%b exp=1", ovf_o);
    end
    for (int i = 0; i < 4; i++) begin
      addr = AW'(12'h200 + i);
      checks++;
      if ({mem_we_o, mem_addr_o} !== {1'b1, addr}) begin
        failures++;
        $display("FAIL ovf_drain_%0d got we=%b addr=%h exp 1 %h", i, mem_we_o, mem_addr_o, addr);
      end
      step();
      #1;
    end
    checks++;
    if ({fifo_empty_o, mem_req_o, ovf_o} !== 3'b101) begin
      failures++;
      $display("FAIL ovf_sticky got empty=%b req=%b ovf=%b exp 1 0 1", fifo_empty_o, mem_req_o, ovf_o);
    end
  endtask

  task automatic test_reset_mid();
    bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = 12'h060;
    for (int i = 0; i < 2; i++) begin
      step();
      prog_we_i = 1'b1; prog_addr_i = AW'(12'h300 + i); prog_wdata_i = 32'hC0 + i;
    end
    step();
    prog_we_i = 1'b0; rst_i = 1'b1;
    #1;
    checks++;
    if ({bus_gnt_o, fifo_empty_o} !== 2'b10) begin
      failures++; $display("FAIL rst_mid_pre got gnt=%b empty=%b exp 1 0", bus_gnt_o, fifo_empty_o);
    end
    step();
    rst_i = 1'b0; bus_req_i = 1'b0;
    #1;
    checks++;
    if ({fifo_empty_o, bus_rvalid_o, ovf_o} !== 3'b100) begin
      failures++;
      $display("FAIL rst_mid_post got empty=%b rvalid=%b ovf=%b exp 1 0 0",
               fifo_empty_o, bus_rvalid_o, ovf_o);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_we_o !== 1'b0) begin
        failures++; $display("FAIL rst_mid_no_write_%0d got=%b exp=0", i, mem_we_o);
      end
      step();
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_prog_write();
    test_bus_read();
    test_starvation();
    test_lock();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
